// File: rtl/led_bank_arbiter_if.sv
// LED bank arbiter bus: idle pattern, requests and patterns in; LED drive,
// one-hot grant and busy out. The master side is the pattern sources, the
// slave side is the arbiter.
interface led_bank_arbiter_if;
  logic [11:0] cylon_q;
  logic [2:0]  req;
  logic [11:0] pat0;
  logic [11:0] pat1;
  logic [11:0] pat2;
  logic [11:0] leds;
  logic [2:0]  grant;
  logic        busy;

  modport master (output cylon_q, req, pat0, pat1, pat2,
                  input  leds, grant, busy);
  modport slave  (input  cylon_q, req, pat0, pat1, pat2,
                  output leds, grant, busy);
endinterface

// File: rtl/led_bank_arbiter.sv
// led_bank_arbiter: shares the 12-LED bank between the idle cylon pattern and
// three event requesters. Each owner gets a minimum hold, a forced maximum
// hold and a blank gap before the next owner.
// Optional: define LED_ROUND_ROBIN_EN for round-robin winner selection
// (last-owner pointer); otherwise fixed priority with req[0] highest.
module led_bank_arbiter #(
  parameter int MXPRE      = 21,
  parameter int HOLD_TICKS = 4,
  parameter int MAX_TICKS  = 16,
  parameter int GAP_TICKS  = 1
) (
  input logic               clock,
  input logic               reset_n,
  led_bank_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  localparam logic [4:0] HOLD_C = 5'(HOLD_TICKS);
  localparam logic [4:0] MAX_C  = 5'(MAX_TICKS);
  localparam logic [4:0] GAP_C  = 5'(GAP_TICKS);

  state_t           r_state;
  logic [MXPRE-1:0] r_pre;
  logic [4:0]       r_cnt;
  logic [2:0]       r_block;
  logic [11:0]      r_pat;
  logic [1:0]       r_own;
  logic [11:0]      r_leds;
  logic [2:0]       r_grant;
  logic             r_busy;
`ifdef LED_ROUND_ROBIN_EN
  logic [1:0]       r_ptr;
`endif

  logic        w_tick;
  logic [4:0]  w_cnt_n;
  logic [2:0]  w_elig;
  logic [1:0]  w_win;
  logic [11:0] w_win_pat;
  logic [2:0]  w_own_oh;
  logic        w_own_req;
  logic        w_rel;
  logic        w_force;
  logic        w_gap_done;
  logic        w_do_grant;

  assign w_tick    = &r_pre;
  // Hold decisions use the post-tick count so a hold of N ticks is exactly
  // N*2^MXPRE clocks from the grant edge.
  assign w_cnt_n   = (w_tick && r_cnt != 5'd31) ? r_cnt + 5'd1 : r_cnt;
  assign w_elig    = bus.req & ~r_block;
  assign w_own_oh  = 3'b001 << r_own;
  assign w_own_req = |(bus.req & w_own_oh);
  // A drop on the same tick as the max hold counts as a normal release.
  assign w_rel      = (w_cnt_n >= HOLD_C) && !w_own_req;
  assign w_force    = (w_cnt_n >= MAX_C) && w_own_req;
  assign w_gap_done = (w_cnt_n >= GAP_C);
  assign w_do_grant = (|w_elig) &&
                      ((r_state == IDLE) || (r_state == GAP && w_gap_done));

  // Winner selection among eligible requesters.
  always_comb begin
    w_win = 2'd2;
`ifdef LED_ROUND_ROBIN_EN
    case (r_ptr)
      2'd0:    w_win = w_elig[1] ? 2'd1 : (w_elig[2] ? 2'd2 : 2'd0);
      2'd1:    w_win = w_elig[2] ? 2'd2 : (w_elig[0] ? 2'd0 : 2'd1);
      default: w_win = w_elig[0] ? 2'd0 : (w_elig[1] ? 2'd1 : 2'd2);
    endcase
`else
    if (w_elig[0])      w_win = 2'd0;
    else if (w_elig[1]) w_win = 2'd1;
`endif
  end

  // Pattern of the selected winner.
  always_comb begin
    case (w_win)
      2'd0:    w_win_pat = bus.pat0;
      2'd1:    w_win_pat = bus.pat1;
      default: w_win_pat = bus.pat2;
    endcase
  end

  // Arbitration FSM, tick timing, block mask and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_pre   <= '0;
      r_cnt   <= '0;
      r_block <= '0;
      r_pat   <= '0;
      r_own   <= '0;
      r_leds  <= '0;
      r_grant <= '0;
      r_busy  <= 1'b0;
`ifdef LED_ROUND_ROBIN_EN
      r_ptr   <= 2'd2;
`endif
    end else begin
      r_pre <= r_pre + MXPRE'(1);
      r_cnt <= w_cnt_n;
      // Block clears whenever the requester lets go; set on forced release.
      r_block <= (r_block & bus.req) |
                 ((r_state == SHOW && w_force && !w_rel) ? w_own_oh : 3'b000);
      case (r_state)
        IDLE: begin
          r_leds  <= bus.cylon_q;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
        SHOW: begin
          r_leds <= r_pat;
          if (w_rel || w_force) begin
            r_state <= GAP;
            r_pre   <= '0;
            r_cnt   <= '0;
            r_leds  <= '0;
            r_grant <= '0;
          end
        end
        GAP: begin
          r_leds <= '0;
          if (w_gap_done) begin
            r_state <= IDLE;
            r_leds  <= bus.cylon_q;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
      // A grant from IDLE or the end of GAP overrides the defaults above.
      if (w_do_grant) begin
        r_state <= SHOW;
        r_pre   <= '0;
        r_cnt   <= '0;
        r_pat   <= w_win_pat;
        r_own   <= w_win;
        r_leds  <= w_win_pat;
        r_grant <= 3'b001 << w_win;
        r_busy  <= 1'b1;
`ifdef LED_ROUND_ROBIN_EN
        r_ptr   <= w_win;
`endif
      end
    end
  end

  assign bus.leds  = r_leds;
  assign bus.grant = r_grant;
  assign bus.busy  = r_busy;

endmodule
